// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler
//   Frame-rate game scheduler for the obstacle and coin spawners. It keeps one
//   obstacle on screen at a time and enforces a minimum frame gap between
//   obstacles. Difficulty ramps over time: the level rises, the gap shrinks
//   and the spawn threshold grows. Coins never launch on an obstacle frame.
// Ports
//   clk          frame clock (rising edge, one tick per video frame)
//   rst_n        async active-low reset
//   en           high while the game is in play
//   random       LFSR sample, refreshed every frame
//   obst_active  active flags reported by the obstacle spawners
//   obst_en      one-hot, single-cycle spawn request (combinational in PICK)
//   coin_en      per-lane coin enable (0 left, 1 mid, 2 right), registered
//   level        difficulty level, saturating at MAX_LEVEL
//   speed        BASE_SPEED + 2*level
//   busy         high while an obstacle is in flight
module obstacle_scheduler #(
  parameter int N_OBST       = 4,
  parameter int BASE_GAP     = 60,
  parameter int MIN_GAP      = 15,
  parameter int GAP_STEP     = 5,
  parameter int LEVEL_FRAMES = 600,
  parameter int MAX_LEVEL    = 9,
  parameter int BASE_THRESH  = 4,
  parameter int BASE_SPEED   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [19:0]       random,
  input  logic [N_OBST-1:0] obst_active,
  output logic [N_OBST-1:0] obst_en,
  output logic [2:0]        coin_en,
  output logic [3:0]        level,
  output logic [5:0]        speed,
  output logic              busy
);

  localparam int IW = (N_OBST > 1) ? $clog2(N_OBST) : 1;
  localparam int FW = $clog2(LEVEL_FRAMES);

  typedef enum logic [1:0] {IDLE, GAP, PICK, BUSY} state_t;

  state_t        state, state_nxt;
  logic [7:0]    gap_cnt, gap_cnt_nxt;
  logic [FW-1:0] frame_cnt;
  logic          busy_first, busy_first_nxt;
  logic [2:0]    coin_q, coin_raw;
  logic [3:0]    thresh;
  logic [4:0]    thresh_sum;
  logic          hit;
  logic [IW-1:0] idx;
  logic          unused_bits;

  // Gap shrinks by GAP_STEP per level, floored at MIN_GAP. The compare is done
  // before the subtract so the 8-bit result can never wrap.
  function automatic logic [7:0] gap_of(input logic [3:0] lvl);
    logic [7:0] dec;
    dec = 8'(lvl) * 8'(GAP_STEP);
    if (dec >= 8'(BASE_GAP - MIN_GAP)) return 8'(MIN_GAP);
    else                               return 8'(BASE_GAP) - dec;
  endfunction

  assign thresh_sum = {1'b0, level} + 5'(BASE_THRESH);
  assign thresh     = (thresh_sum > 5'd15) ? 4'd15 : thresh_sum[3:0];
  assign idx        = random[IW-1:0];
  // en is folded in so a pulse is suppressed when play stops the same frame.
  assign hit        = en && (random[7:4] < thresh) && (obst_active == '0);

  // Lane i launches a coin when three adjacent random bits are all set.
  always_comb begin
    coin_raw = '0;
    for (int i = 0; i < 3; i++) coin_raw[i] = &random[8+3*i +: 3];
  end

  assign unused_bits = ^random;

  always_comb begin
    state_nxt      = state;
    gap_cnt_nxt    = gap_cnt;
    busy_first_nxt = 1'b0;
    obst_en        = '0;
    case (state)
      IDLE: if (en) begin
        state_nxt   = GAP;
        gap_cnt_nxt = gap_of(4'd0);
      end
      GAP: begin
        if (gap_cnt == 8'd0) state_nxt = PICK;
        else                 gap_cnt_nxt = gap_cnt - 8'd1;
      end
      PICK: if (hit) begin
        obst_en[idx]   = 1'b1;
        state_nxt      = BUSY;
        busy_first_nxt = 1'b1;
      end
      // The spawner raises obst_active one frame after the request, so the
      // first BUSY frame cannot trust a low obst_active.
      BUSY: if (!busy_first && (obst_active == '0)) begin
        state_nxt   = GAP;
        gap_cnt_nxt = gap_of(level);
      end
      default: state_nxt = IDLE;
    endcase
    if (!en) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gap_cnt    <= 8'd0;
      busy_first <= 1'b0;
      coin_q     <= 3'd0;
    end else begin
      state      <= state_nxt;
      gap_cnt    <= gap_cnt_nxt;
      busy_first <= busy_first_nxt;
      coin_q     <= (state_nxt != IDLE) ? coin_raw : 3'd0;
    end
  end

  // Level ramp: counts every in-play frame; entering play from IDLE restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level     <= 4'd0;
      frame_cnt <= '0;
    end else if (state == IDLE) begin
      if (en) begin
        level     <= 4'd0;
        frame_cnt <= '0;
      end
    end else if (frame_cnt == FW'(LEVEL_FRAMES - 1)) begin
      frame_cnt <= '0;
      if (level != 4'(MAX_LEVEL)) level <= level + 4'd1;
    end else begin
      frame_cnt <= frame_cnt + FW'(1);
    end
  end

  // Coins are masked on any frame that issues an obstacle request.
  assign coin_en = ((state != IDLE) && (obst_en == '0)) ? coin_q : 3'd0;
  assign speed   = 6'(BASE_SPEED) + {1'b0, level, 1'b0};
  assign busy    = (state == BUSY);

endmodule

// File: tb/tb_obstacle_scheduler.sv
module tb_obstacle_scheduler;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [19:0] random = '0;
  logic [3:0]  obst_active = '0;
  logic [3:0]  obst_en;
  logic [2:0]  coin_en;
  logic [3:0]  level;
  logic [5:0]  speed;
  logic        busy;

  int checks = 0;
  int failures = 0;

  obstacle_scheduler dut (
    .clk(clk), .rst_n(rst_n), .en(en), .random(random),
    .obst_active(obst_active), .obst_en(obst_en), .coin_en(coin_en),
    .level(level), .speed(speed), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (5) step();
    checks++; if (obst_en !== 4'b0) begin failures++; $display("FAIL reset_obst_en got=%b exp=0000", obst_en); end
    checks++; if (coin_en !== 3'b0) begin failures++; $display("FAIL reset_coin_en got=%b exp=000", coin_en); end
    checks++; if (level !== 4'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (speed !== 6'd32) begin failures++; $display("FAIL reset_speed got=%0d exp=32", speed); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  // Threshold never met: sits in PICK with no pulse, then a passing sample fires lane 2.
  task automatic test_gap_pick();
    int bad;
    bad = 0;
    random = 20'hFFFF0; obst_active = '0; en = 1'b1;
    step();
    for (int k = 1; k <= 100; k++) begin
      step();
      if (obst_en !== 4'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL pick_hold_no_pulse got=%0d pulses exp=0", bad); end
    checks++; if (coin_en !== 3'b111) begin failures++; $display("FAIL pick_coin got=%b exp=111", coin_en); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL pick_busy got=%b exp=0", busy); end
    random = 20'h00002; #1;
    checks++; if (obst_en !== 4'b0100) begin failures++; $display("FAIL pulse_onehot got=%b exp=0100", obst_en); end
    checks++; if (coin_en !== 3'b000) begin failures++; $display("FAIL pulse_coin_mask got=%b exp=000", coin_en); end
    step();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_after_pulse got=%b exp=1", busy); end
    checks++; if (obst_en !== 4'b0) begin failures++; $display("FAIL single_cycle_pulse got=%b exp=0000", obst_en); end
  endtask

  // Busy tracks the spawner; the next pulse waits a full 60-frame gap after it clears.
  task automatic test_busy_hold();
    int bad, k;
    bad = 0;
    obst_active = 4'b0100;
    repeat (50) begin
      step();
      if (busy !== 1'b1 || obst_en !== 4'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL busy_hold got=%0d bad cycles exp=0", bad); end
    obst_active = 4'b0;
    for (k = 0; k < 200; k++) begin
      step();
      if (obst_en !== 4'b0) break;
    end
    checks++; if (k < 61 || k > 62) begin failures++; $display("FAIL gap_after_busy got=%0d cycles exp=61..62", k); end
    checks++; if (obst_en !== 4'b0100) begin failures++; $display("FAIL second_pulse got=%b exp=0100", obst_en); end
  endtask

  // Level ramp over 9 levels plus pulse spacing (gap+4) at levels 0, 5 and 9.
  task automatic test_level_ramp();
    int prev, exp_lvl;
    bit d0, d5, d9;
    prev = -1; d0 = 0; d5 = 0; d9 = 0;
    en = 1'b0; obst_active = '0; random = 20'h0;
    step();
    en = 1'b1;
    step();
    for (int k = 1; k <= 5500; k++) begin
      step();
      exp_lvl = (k / 600 > 9) ? 9 : k / 600;
      if ((k % 600 == 0 || k % 600 == 599) && k <= 5410) begin
        checks++;
        if (level !== 4'(exp_lvl)) begin failures++; $display("FAIL level_k%0d got=%0d exp=%0d", k, level, exp_lvl); end
      end
      if (obst_en !== 4'b0) begin
        if (prev < 0) begin
          checks++; if (k != 61) begin failures++; $display("FAIL first_pulse got=%0d exp=61", k); end
        end else if (!d0 && prev >= 61 && k < 600) begin
          d0 = 1; checks++;
          if (k - prev != 64) begin failures++; $display("FAIL spacing_l0 got=%0d exp=64", k - prev); end
        end else if (!d5 && prev >= 3000 && k < 3600) begin
          d5 = 1; checks++;
          if (k - prev != 39) begin failures++; $display("FAIL spacing_l5 got=%0d exp=39", k - prev); end
        end else if (!d9 && prev >= 5400) begin
          d9 = 1; checks++;
          if (k - prev != 19) begin failures++; $display("FAIL spacing_l9 got=%0d exp=19", k - prev); end
        end
        prev = k;
      end
    end
    checks++; if (!(d0 && d5 && d9)) begin failures++; $display("FAIL spacing_seen got=%0d%0d%0d exp=111", d0, d5, d9); end
    checks++; if (level !== 4'd9) begin failures++; $display("FAIL level_sat got=%0d exp=9", level); end
    checks++; if (speed !== 6'd50) begin failures++; $display("FAIL speed_l9 got=%0d exp=50", speed); end
  endtask

  // Dropping en in BUSY returns to IDLE; re-entry restarts at level 0 with a 60 gap.
  task automatic test_en_drop();
    int k;
    for (k = 0; k < 100; k++) begin
      step();
      if (obst_en !== 4'b0) break;
    end
    checks++; if (k >= 100) begin failures++; $display("FAIL drop_find_pulse got=timeout exp=pulse"); end
    step();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL drop_in_busy got=%b exp=1", busy); end
    en = 1'b0;
    step();
    checks++; if (busy !== 1'b0 || obst_en !== 4'b0) begin failures++; $display("FAIL drop_idle got=busy%b obst%b exp=busy0 obst0000", busy, obst_en); end
    checks++; if (level !== 4'd9 || coin_en !== 3'b0) begin failures++; $display("FAIL idle_hold got=lvl%0d coin%b exp=lvl9 coin000", level, coin_en); end
    en = 1'b1;
    step();
    checks++; if (level !== 4'd0 || speed !== 6'd32) begin failures++; $display("FAIL reentry got=lvl%0d spd%0d exp=lvl0 spd32", level, speed); end
    for (k = 1; k < 200; k++) begin
      step();
      if (obst_en !== 4'b0) break;
    end
    checks++; if (k != 61) begin failures++; $display("FAIL reentry_gap got=%0d exp=61", k); end
  endtask

  // Coin lane decode, coin masking on the pulse frame, then async reset mid-GAP.
  task automatic test_coin();
    logic [2:0] coin_prev;
    int k;
    repeat (3) step();
    random = 20'h00700; step();
    checks++; if (coin_en !== 3'b001) begin failures++; $display("FAIL coin_lane0 got=%b exp=001", coin_en); end
    random = 20'h1FF00; step();
    checks++; if (coin_en !== 3'b111) begin failures++; $display("FAIL coin_all got=%b exp=111", coin_en); end
    random = 20'h00E00; step();
    checks++; if (coin_en !== 3'b000) begin failures++; $display("FAIL coin_none got=%b exp=000", coin_en); end
    random = 20'h00700;
    coin_prev = 3'b0;
    for (k = 0; k < 100; k++) begin
      coin_prev = coin_en;
      step();
      if (obst_en !== 4'b0) break;
    end
    checks++; if (obst_en !== 4'b0001 || coin_en !== 3'b000) begin failures++; $display("FAIL coin_pulse got=obst%b coin%b exp=obst0001 coin000", obst_en, coin_en); end
    checks++; if (coin_prev !== 3'b001) begin failures++; $display("FAIL coin_pre_pulse got=%b exp=001", coin_prev); end
    repeat (3) step();
    random = 20'h1FF00; step();
    #2 rst_n = 1'b0; #1;
    checks++; if (coin_en !== 3'b0 || obst_en !== 4'b0 || busy !== 1'b0) begin failures++; $display("FAIL async_reset_out got=coin%b obst%b busy%b exp=0", coin_en, obst_en, busy); end
    checks++; if (level !== 4'd0 || speed !== 6'd32) begin failures++; $display("FAIL async_reset_lvl got=lvl%0d spd%0d exp=lvl0 spd32", level, speed); end
    step();
    rst_n = 1'b1;
  endtask

  // en falling on a frame that would otherwise pulse: no pulse, then IDLE.
  task automatic test_en_fall_pick();
    random = 20'hFFFF0; en = 1'b1;
    repeat (70) step();
    en = 1'b0; random = 20'h0; #1;
    checks++; if (obst_en !== 4'b0) begin failures++; $display("FAIL en_fall_pulse got=%b exp=0000", obst_en); end
    step();
    checks++; if (busy !== 1'b0 || coin_en !== 3'b0) begin failures++; $display("FAIL en_fall_idle got=busy%b coin%b exp=0", busy, coin_en); end
  endtask

  initial begin
    test_reset();
    test_gap_pick();
    test_busy_hold();
    test_level_ramp();
    test_en_drop();
    test_coin();
    test_en_fall_pick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
